// File: rtl/queue_push_arbiter_if.sv
// Push-side bundle between producers, the arbiter and the queue.
// slave: arbiter side; master: producer/queue side.
interface queue_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_IN;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_IN;
  logic [NUM_REQ-1:0]            grant_OUT;
  logic                          qPushReq_OUT;
  logic [DATA_WIDTH-1:0]         qData_OUT;
  logic                          qFull_IN;
  logic                          flush_IN;
  logic                          busy_OUT;

  modport slave (
    input  req_IN, reqData_IN, qFull_IN, flush_IN,
    output grant_OUT, qPushReq_OUT, qData_OUT, busy_OUT
  );

  modport master (
    output req_IN, reqData_IN, qFull_IN, flush_IN,
    input  grant_OUT, qPushReq_OUT, qData_OUT, busy_OUT
  );
endinterface

// File: rtl/queue_push_arbiter.sv
// Round-robin push arbiter with a 1-entry stage in front of a circular FIFO.
// Define QARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module queue_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  queue_push_arbiter_if.slave   bus
);

  logic                  stageValid_r;
  logic [DATA_WIDTH-1:0] qData_r;
  logic                  qPush_s;
  logic                  canAccept_s;
  logic                  grantValid_s;
  logic                  winFound_s;
  logic [IDX_WIDTH-1:0]  winIdx_s;
  logic [NUM_REQ-1:0]    grant_s;

`ifdef QARB_FIXED_PRIO_EN
  // Descending scan so the lowest-indexed request is the last one kept.
  function automatic logic [IDX_WIDTH:0] pickWinner(input logic [NUM_REQ-1:0] req);
    logic [IDX_WIDTH:0] result;
    result = {(IDX_WIDTH+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) result = {1'b1, IDX_WIDTH'(k)};
      else        result = result;
    end
    return result;
  endfunction
`else
  logic [IDX_WIDTH-1:0] rrPtr_r;
  logic [IDX_WIDTH-1:0] rrNext_s;

  // Descending offset scan from ptr, so the nearest request at or after ptr wins.
  function automatic logic [IDX_WIDTH:0] pickWinner(input logic [NUM_REQ-1:0] req,
                                                    input logic [IDX_WIDTH-1:0] ptr);
    logic [IDX_WIDTH:0] result;
    int idx;
    result = {(IDX_WIDTH+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
      if (req[idx[IDX_WIDTH-1:0]]) result = {1'b1, idx[IDX_WIDTH-1:0]};
      else                         result = result;
    end
    return result;
  endfunction
`endif

  // Push/accept qualification, winner selection and one-hot grant.
  always_comb begin
`ifdef QARB_FIXED_PRIO_EN
    {winFound_s, winIdx_s} = pickWinner(bus.req_IN);
`else
    {winFound_s, winIdx_s} = pickWinner(bus.req_IN, rrPtr_r);
    rrNext_s = (winIdx_s == IDX_WIDTH'(NUM_REQ - 1)) ? {IDX_WIDTH{1'b0}}
                                                     : winIdx_s + IDX_WIDTH'(1);
`endif
    qPush_s      = !reset && stageValid_r && !bus.qFull_IN && !bus.flush_IN;
    // The stage may refill in the same cycle it drains.
    canAccept_s  = !reset && !bus.flush_IN && (!stageValid_r || qPush_s);
    grantValid_s = canAccept_s && winFound_s;
    if (grantValid_s) grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winIdx_s;
    else              grant_s = {NUM_REQ{1'b0}};
  end

  // Stage register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid_r <= 1'b0;
      qData_r      <= {DATA_WIDTH{1'b0}};
`ifndef QARB_FIXED_PRIO_EN
      rrPtr_r      <= {IDX_WIDTH{1'b0}};
`endif
    end else if (bus.flush_IN) begin
      stageValid_r <= 1'b0;
`ifndef QARB_FIXED_PRIO_EN
      rrPtr_r      <= {IDX_WIDTH{1'b0}};
`endif
    end else if (grantValid_s) begin
      stageValid_r <= 1'b1;
      qData_r      <= bus.reqData_IN[winIdx_s*DATA_WIDTH +: DATA_WIDTH];
`ifndef QARB_FIXED_PRIO_EN
      rrPtr_r      <= rrNext_s;
`endif
    end else if (qPush_s) begin
      stageValid_r <= 1'b0;
    end else begin
      stageValid_r <= stageValid_r;
    end
  end

  assign bus.grant_OUT    = grant_s;
  assign bus.qPushReq_OUT = qPush_s;
  assign bus.qData_OUT    = qData_r;
  assign bus.busy_OUT     = stageValid_r;

endmodule
